mag_comp4: RTL and testbench

- Registered unsigned/signed magnitude comparator: A vs B, default 4-bit.
- Produces mutually exclusive AgtB / AltB / AeqB flags.
- Carries cascade inputs (74x85 style) so multiple instances chain into wider comparators.
- Sits in the datapath wherever a one-cycle-registered compare result is needed; valid strobe travels alongside the result.

---
 rtl/mag_comp_pkg.sv | 45 ++++
 rtl/mag_comp_slice.sv | 26 ++
 rtl/mag_comp4.sv | 73 +++++++
 tb/tb_mag_comp4.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mag_comp_pkg.sv
// Shared types and helpers for the registered magnitude comparator family.
// The 2-bit result code is what travels along the slice cascade chain.
package mag_comp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10
    } cmp_result_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_flags_t;

    // One-hot flags from an encoded result; the unused code falls back to equal
    function automatic cmp_flags_t decodeResult(input cmp_result_t res);
        cmp_flags_t flags;
        flags = '0;
        case (res)
            CMP_GT:  flags.gt = 1'b1;
            CMP_LT:  flags.lt = 1'b1;
            default: flags.eq = 1'b1;
        endcase
        return flags;
    endfunction

    // External cascade pins to a result code: eq wins, then gt, then lt,
    // and an all-zero cascade is treated as equal
    function automatic cmp_result_t resolveCascade(input logic gtIn, input logic ltIn,
                                                   input logic eqIn);
        cmp_result_t res;
        if (eqIn)
            res = CMP_EQ;
        else if (gtIn)
            res = CMP_GT;
        else if (ltIn)
            res = CMP_LT;
        else
            res = CMP_EQ;
        return res;
    endfunction

endpackage

// File: rtl/mag_comp_slice.sv
// Combinational 4-bit compare stage. The highest differing bit decides;
// if all four bits match, the lower-order result is passed through.
module mag_comp_slice
    import mag_comp_pkg::*;
(
    input  logic [3:0]  a,
    input  logic [3:0]  b,
    input  cmp_result_t cascIn,
    input  logic        signedTop,
    output cmp_result_t result
);

    // MSB-first priority; in the signed top slice a set sign bit means smaller
    always_comb begin
        result = cascIn;
        if (a[3] != b[3])
            result = (a[3] ^ signedTop) ? CMP_GT : CMP_LT;
        else if (a[2] != b[2])
            result = a[2] ? CMP_GT : CMP_LT;
        else if (a[1] != b[1])
            result = a[1] ? CMP_GT : CMP_LT;
        else if (a[0] != b[0])
            result = a[0] ? CMP_GT : CMP_LT;
    end

endmodule

// File: rtl/mag_comp4.sv
// Registered magnitude comparator with 74x85-style cascade inputs.
// Operands are widened to whole 4-bit slices, compared LSB slice first
// through the cascade chain, and the decoded flags are registered once.
module mag_comp4
    import mag_comp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             gt_in,
    input  logic             lt_in,
    input  logic             eq_in,
    output logic             out_valid,
    output logic             AgtB,
    output logic             AltB,
    output logic             AeqB
);

    localparam int NSLICE = (WIDTH + 3) / 4;
    localparam int EXTW   = NSLICE * 4;

    logic [EXTW-1:0] aExt;
    logic [EXTW-1:0] bExt;
    cmp_result_t     chain [NSLICE+1];
    cmp_flags_t      flags;

    // Pad to a whole number of slices: zero fill for unsigned, sign fill for signed
    if (EXTW == WIDTH) begin : gNoExt
        assign aExt = A;
        assign bExt = B;
    end else begin : gExt
        logic aFill;
        logic bFill;
        assign aFill = SIGNED & A[WIDTH-1];
        assign bFill = SIGNED & B[WIDTH-1];
        assign aExt  = {{(EXTW-WIDTH){aFill}}, A};
        assign bExt  = {{(EXTW-WIDTH){bFill}}, B};
    end

    assign chain[0] = resolveCascade(gt_in, lt_in, eq_in);

    for (genvar s = 0; s < NSLICE; s++) begin : gSlice
        mag_comp_slice uSlice (
            .a         (aExt[4*s +: 4]),
            .b         (bExt[4*s +: 4]),
            .cascIn    (chain[s]),
            .signedTop (SIGNED && (s == NSLICE - 1)),
            .result    (chain[s+1])
        );
    end

    // Result register: valid follows in_valid every cycle, flags hold through bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            flags     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                flags <= decodeResult(chain[NSLICE]);
        end
    end

    assign AgtB = flags.gt;
    assign AltB = flags.lt;
    assign AeqB = flags.eq;

endmodule

// File: tb/tb_mag_comp4.sv
// Self-checking bench for mag_comp4: directed vectors on 4-bit unsigned and
// signed instances, bubble and async-reset behaviour, then random traffic on
// 4/8-bit unsigned and 4/6-bit signed instances against an integer model.
module tb_mag_comp4;

    logic       clk;
    logic       rst;
    logic       inValid;
    logic       gtIn;
    logic       ltIn;
    logic       eqIn;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic [5:0] a6, b6;

    logic ov4, gt4, lt4, eq4;
    logic ov4s, gt4s, lt4s, eq4s;
    logic ov8, gt8, lt8, eq8;
    logic ov6s, gt6s, lt6s, eq6s;

    logic       obsOv [4];
    logic [2:0] obsF  [4];
    logic [2:0] expF  [4];
    logic       expOv;
    string      instName [4];

    int passCnt;
    int totalCnt;

    mag_comp4 #(.WIDTH(4), .SIGNED(1'b0)) u4 (
        .clk(clk), .rst(rst), .in_valid(inValid), .A(a4), .B(b4),
        .gt_in(gtIn), .lt_in(ltIn), .eq_in(eqIn),
        .out_valid(ov4), .AgtB(gt4), .AltB(lt4), .AeqB(eq4)
    );

    mag_comp4 #(.WIDTH(4), .SIGNED(1'b1)) u4s (
        .clk(clk), .rst(rst), .in_valid(inValid), .A(a4), .B(b4),
        .gt_in(gtIn), .lt_in(ltIn), .eq_in(eqIn),
        .out_valid(ov4s), .AgtB(gt4s), .AltB(lt4s), .AeqB(eq4s)
    );

    mag_comp4 #(.WIDTH(8), .SIGNED(1'b0)) u8 (
        .clk(clk), .rst(rst), .in_valid(inValid), .A(a8), .B(b8),
        .gt_in(gtIn), .lt_in(ltIn), .eq_in(eqIn),
        .out_valid(ov8), .AgtB(gt8), .AltB(lt8), .AeqB(eq8)
    );

    mag_comp4 #(.WIDTH(6), .SIGNED(1'b1)) u6s (
        .clk(clk), .rst(rst), .in_valid(inValid), .A(a6), .B(b6),
        .gt_in(gtIn), .lt_in(ltIn), .eq_in(eqIn),
        .out_valid(ov6s), .AgtB(gt6s), .AltB(lt6s), .AeqB(eq6s)
    );

    assign obsOv[0] = ov4;
    assign obsOv[1] = ov4s;
    assign obsOv[2] = ov8;
    assign obsOv[3] = ov6s;
    assign obsF[0]  = {gt4, lt4, eq4};
    assign obsF[1]  = {gt4s, lt4s, eq4s};
    assign obsF[2]  = {gt8, lt8, eq8};
    assign obsF[3]  = {gt6s, lt6s, eq6s};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret operands as integers, compare numerically, and only
    // consult the cascade pins on a tie. Returns {gt, lt, eq}.
    function automatic logic [2:0] refFlags(input int w, input bit sgn,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic gi, input logic li, input logic ei);
        longint span, va, vb;
        span = longint'(1) << w;
        va = longint'(a) % span;
        vb = longint'(b) % span;
        if (sgn && va >= span / 2) va = va - span;
        if (sgn && vb >= span / 2) vb = vb - span;
        if (va > vb) return 3'b100;
        if (va < vb) return 3'b010;
        if (ei) return 3'b001;
        if (gi) return 3'b100;
        if (li) return 3'b010;
        return 3'b001;
    endfunction

    // Advance one clock, updating the expected register contents first
    task automatic stepCycle();
        if (rst) begin
            for (int i = 0; i < 4; i++) expF[i] = 3'b000;
            expOv = 1'b0;
        end else begin
            if (inValid) begin
                expF[0] = refFlags(4, 1'b0, 32'(a4), 32'(b4), gtIn, ltIn, eqIn);
                expF[1] = refFlags(4, 1'b1, 32'(a4), 32'(b4), gtIn, ltIn, eqIn);
                expF[2] = refFlags(8, 1'b0, 32'(a8), 32'(b8), gtIn, ltIn, eqIn);
                expF[3] = refFlags(6, 1'b1, 32'(a6), 32'(b6), gtIn, ltIn, eqIn);
            end
            expOv = inValid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 4; i++) begin
            totalCnt++;
            if ({obsOv[i], obsF[i]} !== 4'b0000)
                $display("FAIL reset_async %s: got ov/flags=%b, want 0000", instName[i], {obsOv[i], obsF[i]});
            else passCnt++;
        end
        inValid = 1'b1;
        stepCycle();
        for (int i = 0; i < 4; i++) begin
            totalCnt++;
            if ({obsOv[i], obsF[i]} !== 4'b0000)
                $display("FAIL reset_held %s: got ov/flags=%b, want 0000", instName[i], {obsOv[i], obsF[i]});
            else passCnt++;
        end
        rst = 1'b0;
    endtask

    // Back-to-back directed vectors on both 4-bit instances, one per cycle
    task automatic test_directed();
        logic [3:0] ta [11] = '{4'b1100, 4'b0011, 4'b1100, 4'b0000, 4'b1010, 4'b0101,
                                4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b1000};
        logic [3:0] tb [11] = '{4'b0011, 4'b1100, 4'b1100, 4'b0000, 4'b0101, 4'b1010,
                                4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b0111};
        logic [2:0] tc [11] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                                3'b100, 3'b010, 3'b000, 3'b111, 3'b010};
        logic [2:0] eu [11] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b100, 3'b010,
                                3'b100, 3'b010, 3'b001, 3'b001, 3'b100};
        logic [2:0] es [11] = '{3'b010, 3'b100, 3'b001, 3'b001, 3'b010, 3'b100,
                                3'b100, 3'b010, 3'b001, 3'b001, 3'b010};
        for (int k = 0; k < 11; k++) begin
            a4 = ta[k];
            b4 = tb[k];
            {gtIn, ltIn, eqIn} = tc[k];
            inValid = 1'b1;
            stepCycle();
            totalCnt++;
            if (obsOv[0] !== 1'b1 || obsOv[1] !== 1'b1)
                $display("FAIL directed_valid[%0d]: got ov=%b%b, want 11", k, obsOv[0], obsOv[1]);
            else passCnt++;
            totalCnt++;
            if (obsF[0] !== eu[k])
                $display("FAIL directed_unsigned[%0d] A=%b B=%b: got %b, want %b", k, ta[k], tb[k], obsF[0], eu[k]);
            else passCnt++;
            totalCnt++;
            if (obsF[1] !== es[k])
                $display("FAIL directed_signed[%0d] A=%b B=%b: got %b, want %b", k, ta[k], tb[k], obsF[1], es[k]);
            else passCnt++;
        end
    endtask

    // Bubbles: valid drops, flags keep the last result (1000 vs 0111)
    task automatic test_bubble();
        inValid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            stepCycle();
            totalCnt++;
            if (obsOv[0] !== 1'b0 || obsOv[1] !== 1'b0)
                $display("FAIL bubble_valid[%0d]: got ov=%b%b, want 00", k, obsOv[0], obsOv[1]);
            else passCnt++;
            totalCnt++;
            if (obsF[0] !== 3'b100 || obsF[1] !== 3'b010)
                $display("FAIL bubble_hold[%0d]: got %b/%b, want 100/010", k, obsF[0], obsF[1]);
            else passCnt++;
        end
    endtask

    task automatic test_async_reset();
        a4 = 4'b0011; b4 = 4'b1100; {gtIn, ltIn, eqIn} = 3'b001; inValid = 1'b1;
        stepCycle();
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            totalCnt++;
            if ({obsOv[i], obsF[i]} !== 4'b0000)
                $display("FAIL midreset %s: got ov/flags=%b, want 0000", instName[i], {obsOv[i], obsF[i]});
            else passCnt++;
        end
        stepCycle();
        totalCnt++;
        if ({obsOv[0], obsF[0]} !== 4'b0000)
            $display("FAIL reset_edge: got ov/flags=%b, want 0000", {obsOv[0], obsF[0]});
        else passCnt++;
        rst = 1'b0;
        a4 = 4'b1111; b4 = 4'b1110;
        stepCycle();
        totalCnt++;
        if ({obsOv[0], obsF[0]} !== 4'b1100)
            $display("FAIL post_reset_unsigned: got ov/flags=%b, want 1100", {obsOv[0], obsF[0]});
        else passCnt++;
        totalCnt++;
        if ({obsOv[1], obsF[1]} !== 4'b1100)
            $display("FAIL post_reset_signed: got ov/flags=%b, want 1100", {obsOv[1], obsF[1]});
        else passCnt++;
    endtask

    // Random traffic with bubbles and frequent forced ties to exercise the cascade
    task automatic test_random();
        for (int n = 0; n < 1200; n++) begin
            inValid = ($urandom % 5) != 0;
            a4 = 4'($urandom);
            a8 = 8'($urandom);
            a6 = 6'($urandom);
            b4 = (($urandom % 4) == 0) ? a4 : 4'($urandom);
            b8 = (($urandom % 4) == 0) ? a8 : 8'($urandom);
            b6 = (($urandom % 4) == 0) ? a6 : 6'($urandom);
            {gtIn, ltIn, eqIn} = 3'($urandom);
            stepCycle();
            for (int i = 0; i < 4; i++) begin
                totalCnt++;
                if (obsOv[i] !== expOv || obsF[i] !== expF[i])
                    $display("FAIL random[%0d] %s: got ov=%b flags=%b, want ov=%b flags=%b",
                             n, instName[i], obsOv[i], obsF[i], expOv, expF[i]);
                else passCnt++;
                totalCnt++;
                if ($countones(obsF[i]) !== 1)
                    $display("FAIL onehot[%0d] %s: got flags=%b, want exactly one set", n, instName[i], obsF[i]);
                else passCnt++;
            end
        end
    endtask

    initial begin
        passCnt  = 0;
        totalCnt = 0;
        instName[0] = "u4";
        instName[1] = "u4s";
        instName[2] = "u8";
        instName[3] = "u6s";
        for (int i = 0; i < 4; i++) expF[i] = 3'b000;
        expOv   = 1'b0;
        rst     = 1'b1;
        inValid = 1'b0;
        gtIn    = 1'b0;
        ltIn    = 1'b0;
        eqIn    = 1'b1;
        a4 = '0; b4 = '0;
        a8 = '0; b8 = '0;
        a6 = '0; b6 = '0;

        test_reset();
        test_directed();
        test_bubble();
        test_async_reset();
        test_random();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
